// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared op codes, flash commands, status bits and state encodings
package flash_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_PROGRAM = 2'b01,
    OP_ERASE   = 2'b10,
    OP_STATUS  = 2'b11
  } op_e;

  localparam logic [7:0] CMD_READ_ARRAY = 8'hFF;
  localparam logic [7:0] CMD_READ_SR    = 8'h70;
  localparam logic [7:0] CMD_PROGRAM    = 8'h40;
  localparam logic [7:0] CMD_ERASE      = 8'h20;
  localparam logic [7:0] CMD_CONFIRM    = 8'hD0;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_VPEN_ERR  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD,
    ST_POLL_CMD,
    ST_POLL_RD,
    ST_RESTORE,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_WE,
    PH_HOLD,
    PH_OE,
    PH_REC
  } phase_e;

  function automatic logic [7:0] first_cmd(op_e o);
    case (o)
      OP_READ:    return CMD_READ_ARRAY;
      OP_PROGRAM: return CMD_PROGRAM;
      OP_ERASE:   return CMD_ERASE;
      default:    return CMD_READ_SR;
    endcase
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// rtl/flash_bus_cycle.sv - one timed flash bus write (SETUP/WE/HOLD) or read (OE/REC)
module flash_bus_cycle
  import flash_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_write,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              oe_n,
  output logic              we_n,
  output logic              data_en,
  output logic [DATA_W-1:0] data_out
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  phase_e            phase_q;
  logic [CW-1:0]     cnt_q;
  logic              oe_n_q, we_n_q, den_q;
  logic [DATA_W-1:0] dout_q, rdata_q;
  logic              last;

  assign last = (cnt_q == CNT_LAST);
  // ack is combinational so the sequencer can chain the next cycle with no gap
  assign ack      = ((phase_q == PH_HOLD) || (phase_q == PH_REC)) && last;
  assign rdata    = rdata_q;
  assign oe_n     = oe_n_q;
  assign we_n     = we_n_q;
  assign data_en  = den_q;
  assign data_out = dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      den_q   <= 1'b0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else if ((phase_q == PH_IDLE) || ack) begin
      cnt_q  <= '0;
      we_n_q <= 1'b1;
      if (start && is_write) begin
        phase_q <= PH_SETUP;
        den_q   <= 1'b1;
        dout_q  <= wdata;
        oe_n_q  <= 1'b1;
      end else if (start) begin
        phase_q <= PH_OE;
        den_q   <= 1'b0;
        oe_n_q  <= 1'b0;
      end else begin
        phase_q <= PH_IDLE;
        den_q   <= 1'b0;
        oe_n_q  <= 1'b1;
      end
    end else if (last) begin
      cnt_q <= '0;
      case (phase_q)
        PH_SETUP: begin
          phase_q <= PH_WE;
          we_n_q  <= 1'b0;
        end
        PH_WE: begin
          phase_q <= PH_HOLD;
          we_n_q  <= 1'b1;
        end
        PH_OE: begin
          phase_q <= PH_REC;
          oe_n_q  <= 1'b1;
          rdata_q <= data_in;
        end
        default: phase_q <= PH_IDLE;
      endcase
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/flash_rw_ctrl.sv
// rtl/flash_rw_ctrl.sv - NOR flash read/program/erase/status sequencer with SR polling
module flash_rw_ctrl
  import flash_pkg::*;
#(
  parameter int ADDR_W   = 22,
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 4,
  parameter int POLL_MAX = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W:0]   flash_addr,
  inout  wire  [DATA_W-1:0] flash_data,
  output logic              flash_byte,
  output logic              flash_vpen,
  output logic              flash_rp,
  output logic              flash_ce,
  output logic              flash_oe,
  output logic              flash_we
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX);

  state_e            state_q;
  op_e               op_q;
  logic              step_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [ADDR_W:0]   flash_addr_q;
  logic [PW-1:0]     poll_cnt_q;
  logic              busy_q, done_q, err_q;

  logic              bus_start, bus_is_write, bus_ack, bus_den;
  logic [DATA_W-1:0] bus_wdata, bus_rdata, bus_dout, sr_word;
  logic              two_cmd, sr_ready, sr_err, poll_timeout;

  function automatic logic [DATA_W-1:0] cmd_word(logic [7:0] c);
    return DATA_W'(c);
  endfunction

  assign sr_word      = {{(DATA_W-8){1'b0}}, bus_rdata[7:0]};
  assign sr_ready     = bus_rdata[SR_READY];
  assign sr_err       = bus_rdata[SR_ERASE_ERR] | bus_rdata[SR_PROG_ERR] | bus_rdata[SR_VPEN_ERR];
  assign poll_timeout = (poll_cnt_q == POLL_LAST);
  assign two_cmd      = (op_q == OP_PROGRAM) || (op_q == OP_ERASE);

  // Next bus cycle is launched on the same edge the previous one acks.
  always_comb begin
    bus_start    = 1'b0;
    bus_is_write = 1'b1;
    bus_wdata    = '0;
    case (state_q)
      ST_IDLE: if (req) begin
        bus_start = 1'b1;
        bus_wdata = cmd_word(first_cmd(op_e'(op)));
      end
      ST_CMD: if (bus_ack) begin
        bus_start = 1'b1;
        if (!step_q && two_cmd)
          bus_wdata = (op_q == OP_PROGRAM) ? wdata_q : cmd_word(CMD_CONFIRM);
        else if (!two_cmd)
          bus_is_write = 1'b0;
        else
          bus_wdata = cmd_word(CMD_READ_SR);
      end
      ST_POLL_CMD: if (bus_ack) begin
        bus_start    = 1'b1;
        bus_is_write = 1'b0;
      end
      ST_POLL_RD: if (bus_ack) begin
        bus_start = sr_ready || !poll_timeout;
        bus_wdata = sr_ready ? cmd_word(CMD_READ_ARRAY) : cmd_word(CMD_READ_SR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_READ;
      step_q       <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      flash_addr_q <= '0;
      poll_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (req) begin
          op_q         <= op_e'(op);
          wdata_q      <= wdata;
          flash_addr_q <= {addr, 1'b0};
          step_q       <= 1'b0;
          poll_cnt_q   <= '0;
          err_q        <= 1'b0;
          busy_q       <= 1'b1;
          state_q      <= ST_CMD;
        end
        ST_CMD: if (bus_ack) begin
          if (!step_q && two_cmd) begin
            step_q <= 1'b1;
          end else if (!two_cmd) begin
            state_q <= ST_RD;
          end else begin
            state_q    <= ST_POLL_CMD;
            poll_cnt_q <= poll_cnt_q + 1'b1;
          end
        end
        ST_RD: if (bus_ack) begin
          rdata_q <= (op_q == OP_STATUS) ? sr_word : bus_rdata;
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        ST_POLL_CMD: if (bus_ack) state_q <= ST_POLL_RD;
        ST_POLL_RD: if (bus_ack) begin
          rdata_q <= sr_word;
          if (sr_ready) begin
            err_q   <= sr_err;
            state_q <= ST_RESTORE;
          end else if (poll_timeout) begin
            err_q   <= 1'b1;
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q    <= ST_POLL_CMD;
            poll_cnt_q <= poll_cnt_q + 1'b1;
          end
        end
        ST_RESTORE: if (bus_ack) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  flash_bus_cycle #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_bus (
    .clk      (clk),
    .rst      (rst),
    .start    (bus_start),
    .is_write (bus_is_write),
    .wdata    (bus_wdata),
    .data_in  (flash_data),
    .ack      (bus_ack),
    .rdata    (bus_rdata),
    .oe_n     (flash_oe),
    .we_n     (flash_we),
    .data_en  (bus_den),
    .data_out (bus_dout)
  );

  assign flash_data = bus_den ? bus_dout : {DATA_W{1'bz}};
  assign flash_byte = 1'b1;
  assign flash_vpen = 1'b1;
  assign flash_rp   = 1'b1;
  assign flash_ce   = 1'b0;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign flash_addr = flash_addr_q;

endmodule

// File: tb/tb_flash_rw_ctrl.sv
// tb/tb_flash_rw_ctrl.sv - directed bench for flash_rw_ctrl against a behavioural flash model
module tb_flash_rw_ctrl;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst, req;
  logic [1:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy, done, err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W:0]   flash_addr;
  wire  [DATA_W-1:0] flash_data;
  logic              flash_byte, flash_vpen, flash_rp, flash_ce, flash_oe, flash_we;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int log_q[$];

  logic [15:0] arr_word;
  logic [15:0] sr_final;
  int          busy_polls;
  int          n70;
  logic        sr_mode;
  logic [15:0] model_dout;

  always #5 clk = ~clk;

  flash_rw_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .CLK_DIV  (2),
    .POLL_MAX (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .op         (op),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .flash_addr (flash_addr),
    .flash_data (flash_data),
    .flash_byte (flash_byte),
    .flash_vpen (flash_vpen),
    .flash_rp   (flash_rp),
    .flash_ce   (flash_ce),
    .flash_oe   (flash_oe),
    .flash_we   (flash_we)
  );

  // Released bus floats high so a driven-versus-Z bus can be told apart
  pullup pu_data (flash_data);

  assign model_dout = sr_mode ? ((n70 <= busy_polls) ? 16'h0000 : sr_final) : arr_word;
  assign flash_data = (!flash_oe && !flash_ce) ? model_dout : 16'bz;

  always @(posedge flash_we) begin
    log_q.push_back(int'(flash_data));
    if (flash_data == 16'h0070) begin
      sr_mode = 1'b1;
      n70++;
    end else if (flash_data == 16'h00FF) begin
      sr_mode = 1'b0;
    end
  end

  always @(negedge flash_oe) log_q.push_back(-1);

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string tag, input int exp[$]);
    check({tag, " log length"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s log[%0d]", tag, i), (i < log_q.size()) ? log_q[i] : 32'hDEAD_BEEF, exp[i]);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [ADDR_W-1:0] a,
                        input logic [15:0] d, output int lat);
    int n;
    op    = o;
    addr  = a;
    wdata = d;
    req   = 1'b1;
    n     = 0;
    tick();
    while (busy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    req = 1'b0;
    check({tag, " accept"}, busy, 1);
    lat = 0;
    while (done !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    check({tag, " done"}, done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int d0;
    int n;
    rst = 1'b1; req = 1'b0; op = 2'b00; addr = '0; wdata = '0;
    arr_word = 16'hBEEF; sr_final = 16'h0080; busy_polls = 0; n70 = 0; sr_mode = 1'b0;
    repeat (3) tick();

    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset rdata", rdata, 0);
    check("reset oe", flash_oe, 1);
    check("reset we", flash_we, 1);
    check("reset addr", flash_addr, 0);
    check("reset data Z", flash_data, 16'hFFFF);
    check("tie ce/byte/vpen/rp", {flash_ce, flash_byte, flash_vpen, flash_rp}, 4'b0111);
    rst = 1'b0;
    tick();

    // array read
    log_q.delete();
    run_op("read", 2'b00, 22'h000123, 16'h0000, lat);
    check("read latency", lat, 10);
    check("read rdata", rdata, 16'hBEEF);
    check("read err", err, 0);
    check("read flash_addr", flash_addr, 23'h000246);
    check_log("read", '{32'h00FF, -1});
    tick();
    check("done one cycle", done, 0);

    // status read
    log_q.delete(); n70 = 0; busy_polls = 0; sr_final = 16'h0080;
    run_op("status", 2'b11, 22'h000005, 16'h0000, lat);
    check("status latency", lat, 10);
    check("status rdata", rdata, 16'h0080);
    check("status err", err, 0);
    check_log("status", '{32'h0070, -1});
    tick();

    // program, device busy for three polls
    log_q.delete(); n70 = 0; busy_polls = 3; sr_final = 16'h0080;
    run_op("prog", 2'b01, 22'h000010, 16'h1234, lat);
    check("prog latency", lat, 58);
    check("prog rdata", rdata, 16'h0080);
    check("prog err", err, 0);
    check("prog flash_addr", flash_addr, 23'h000020);
    check_log("prog", '{32'h0040, 32'h1234, 32'h0070, -1, 32'h0070, -1,
                        32'h0070, -1, 32'h0070, -1, 32'h00FF});
    tick();

    // erase reporting an erase error
    log_q.delete(); n70 = 0; busy_polls = 0; sr_final = 16'h00A0;
    run_op("erase err", 2'b10, 22'h000200, 16'h0000, lat);
    check("erase err latency", lat, 28);
    check("erase err rdata", rdata, 16'h00A0);
    check("erase err flag", err, 1);
    check_log("erase err", '{32'h0020, 32'h00D0, 32'h0070, -1, 32'h00FF});
    tick();

    // poll timeout after POLL_MAX=4 polls, no restore write
    log_q.delete(); n70 = 0; busy_polls = 1000; sr_final = 16'h0080;
    run_op("timeout", 2'b10, 22'h000300, 16'h0000, lat);
    check("timeout latency", lat, 52);
    check("timeout rdata", rdata, 16'h0000);
    check("timeout err", err, 1);
    check_log("timeout", '{32'h0020, 32'h00D0, 32'h0070, -1, 32'h0070, -1,
                           32'h0070, -1, 32'h0070, -1});
    tick();

    // req pulsed while busy is ignored
    n70 = 0; busy_polls = 0; sr_mode = 1'b0;
    d0 = done_cnt;
    op = 2'b00; addr = 22'h000001; req = 1'b1;
    tick();
    req = 1'b0;
    check("busy accept", busy, 1);
    tick(); tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (30) tick();
    check("busy req ignored done count", done_cnt - d0, 1);
    check("busy req ignored idle", busy, 0);

    // req held high through DONE: accepted in the cycle after DONE
    op = 2'b00; addr = 22'h000002; req = 1'b1;
    n = 0;
    tick();
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("held req done", done, 1);
    tick();
    check("held req idle cycle", busy, 0);
    tick();
    check("held req reaccept", busy, 1);
    req = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("held req second done", done, 1);
    tick();

    // reset during the WE phase of a program
    n70 = 0;
    op = 2'b01; addr = 22'h000040; wdata = 16'h5555; req = 1'b1;
    tick();
    req = 1'b0;
    n = 0;
    while (flash_we !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check("abort reached WE", flash_we, 0);
    rst = 1'b1;
    tick();
    check("abort we", flash_we, 1);
    check("abort oe", flash_oe, 1);
    check("abort data Z", flash_data, 16'hFFFF);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (40) tick();
    check("abort no done", done_cnt - d0, 0);
    check("abort stays idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
